// File: rtl/div_counter_pkg.sv
// Shared types and default sizes for the divider/counter bank.
package div_counter_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_DIV_W = 24;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/div_counter_channel.sv
// One divider/counter channel: STOP/RUN FSM, prescaler and modulo counter.
// A cascaded channel advances on the upstream wrap pulse instead of its own prescaler.
module div_counter_channel
    import div_counter_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit CASCADED = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic             i_ext_adv,
    input  logic [DIV_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_mod,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_running
);

    state_t           r_state;
    logic [DIV_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_wrap;
    logic             w_adv;

    assign w_adv = CASCADED ? i_ext_adv : r_tick;

    // NOTE: reset is sampled on the edge (synchronous) and shares a branch with clear so both win.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_state <= ST_STOP;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            // NOTE: pulses default low; a later non-blocking write in this block overrides it.
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    if (i_run) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!i_run) begin
                        r_state <= ST_STOP;
                    end else begin
                        if (CASCADED) begin
                            r_pre <= '0;
                        end else if (r_pre >= i_div) begin
                            r_pre  <= '0;
                            r_tick <= 1'b1;
                        end else begin
                            r_pre <= r_pre + DIV_W'(1);
                        end
                        if (w_adv) begin
                            if (r_cnt >= i_mod) begin
                                r_cnt  <= '0;
                                r_wrap <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    assign o_tick    = r_tick;
    assign o_cnt     = r_cnt;
    assign o_wrap    = r_wrap;
    assign o_running = (r_state == ST_RUN);

endmodule

// File: rtl/div_counter_bank.sv
// Bank of N_CH divider/counter channels with optional wrap-to-advance cascading.
// Defining DIV_COUNTER_BANK_SNAPSHOT_EN adds iSNAP/oSNAP for an atomic capture of all counts.
module div_counter_bank
    import div_counter_pkg::*;
#(
    parameter int              N_CH    = DEF_N_CH,
    parameter int              DIV_W   = DEF_DIV_W,
    parameter int              CNT_W   = DEF_CNT_W,
    parameter logic [N_CH-1:0] CASCADE = {N_CH{1'b0}}
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [N_CH-1:0]       iRUN,
    input  logic [N_CH-1:0]       iCLR,
    input  logic [N_CH*DIV_W-1:0] iDIV,
    input  logic [N_CH*CNT_W-1:0] iMOD,
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
    input  logic                  iSNAP,
    output logic [N_CH*CNT_W-1:0] oSNAP,
`endif
    output logic [N_CH-1:0]       oTICK,
    output logic [N_CH*CNT_W-1:0] oCNT,
    output logic [N_CH-1:0]       oWRAP,
    output logic [N_CH-1:0]       oRUNNING
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic w_ext_adv;

        // Channel 0 has no upstream neighbour, so its cascade input is tied off.
        if (k == 0) begin : g_first
            assign w_ext_adv = 1'b0;
        end else begin : g_next
            assign w_ext_adv = oWRAP[k-1];
        end

        div_counter_channel #(
            .DIV_W   (DIV_W),
            .CNT_W   (CNT_W),
            .CASCADED(bit'((k > 0) && CASCADE[k]))
        ) u_ch (
            .i_clk    (CLOCK),
            .i_rst    (RESET),
            .i_run    (iRUN[k]),
            .i_clr    (iCLR[k]),
            .i_ext_adv(w_ext_adv),
            .i_div    (iDIV[k*DIV_W +: DIV_W]),
            .i_mod    (iMOD[k*CNT_W +: CNT_W]),
            .o_tick   (oTICK[k]),
            .o_cnt    (oCNT[k*CNT_W +: CNT_W]),
            .o_wrap   (oWRAP[k]),
            .o_running(oRUNNING[k])
        );
    end

`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
    logic [N_CH*CNT_W-1:0] r_snap;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_snap <= '0;
        end else if (iSNAP) begin
            r_snap <= oCNT;
        end
    end

    assign oSNAP = r_snap;
`endif

endmodule

// File: tb/tb_div_counter_bank.sv
// Scoreboard bench for div_counter_bank: a cycle model pushes expected outputs, a monitor pops and compares.
// Directed phases cover prescaler/counter timing, cascade, stop/resume, clear, reset and the optional snapshot.
module tb_div_counter_bank;

    localparam int              N_CH    = 4;
    localparam int              DIV_W   = 24;
    localparam int              CNT_W   = 8;
    localparam logic [N_CH-1:0] CASCADE = 4'b0010;

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       run;
    logic [N_CH-1:0]       clr;
    logic [N_CH*DIV_W-1:0] div;
    logic [N_CH*CNT_W-1:0] mod;
    logic [N_CH-1:0]       tick;
    logic [N_CH*CNT_W-1:0] cnt;
    logic [N_CH-1:0]       wrap;
    logic [N_CH-1:0]       running;
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
    logic                  snap;
    logic [N_CH*CNT_W-1:0] snap_out;
`endif

    div_counter_bank #(
        .N_CH   (N_CH),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W),
        .CASCADE(CASCADE)
    ) u_dut (
        .CLOCK   (clk),
        .RESET   (rst),
        .iRUN    (run),
        .iCLR    (clr),
        .iDIV    (div),
        .iMOD    (mod),
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
        .iSNAP   (snap),
        .oSNAP   (snap_out),
`endif
        .oTICK   (tick),
        .oCNT    (cnt),
        .oWRAP   (wrap),
        .oRUNNING(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: each channel described as plain integers updated once per edge.
    int m_run  [N_CH];
    int m_pre  [N_CH];
    int m_cnt  [N_CH];
    int m_tick [N_CH];
    int m_wrap [N_CH];
    int m_snap [N_CH];

    typedef struct packed {
        logic [N_CH-1:0]       tick;
        logic [N_CH-1:0]       wrap;
        logic [N_CH-1:0]       running;
        logic [N_CH*CNT_W-1:0] cnt;
        logic [N_CH*CNT_W-1:0] snap;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    function automatic void model_step();
        int   old_wrap [N_CH];
        int   old_cnt  [N_CH];
        exp_t e;
        for (int k = 0; k < N_CH; k++) begin
            old_wrap[k] = m_wrap[k];
            old_cnt[k]  = m_cnt[k];
        end
        for (int k = 0; k < N_CH; k++) begin
            int d;
            int md;
            bit casc;
            bit adv;
            d    = int'(div[k*DIV_W +: DIV_W]);
            md   = int'(mod[k*CNT_W +: CNT_W]);
            casc = (k > 0) && CASCADE[k];
            adv  = casc ? (old_wrap[(k > 0) ? k-1 : 0] != 0) : (m_tick[k] != 0);
            if (rst || clr[k]) begin
                m_run[k] = 0; m_pre[k] = 0; m_cnt[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
            end else if (m_run[k] == 0) begin
                m_tick[k] = 0; m_wrap[k] = 0;
                m_run[k]  = run[k] ? 1 : 0;
            end else if (!run[k]) begin
                m_run[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
            end else begin
                if (casc) begin
                    m_pre[k] = 0; m_tick[k] = 0;
                end else if (m_pre[k] >= d) begin
                    m_pre[k] = 0; m_tick[k] = 1;
                end else begin
                    m_pre[k] = m_pre[k] + 1; m_tick[k] = 0;
                end
                m_wrap[k] = 0;
                if (adv) begin
                    if (m_cnt[k] >= md) begin
                        m_cnt[k] = 0; m_wrap[k] = 1;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
            if (rst) m_snap[k] = 0;
            else if (snap) m_snap[k] = old_cnt[k];
`else
            m_snap[k] = 0;
`endif
        end
        e = '0;
        for (int k = 0; k < N_CH; k++) begin
            e.tick[k]                  = (m_tick[k] != 0);
            e.wrap[k]                  = (m_wrap[k] != 0);
            e.running[k]               = (m_run[k] != 0);
            e.cnt[k*CNT_W +: CNT_W]    = m_cnt[k][CNT_W-1:0];
            e.snap[k*CNT_W +: CNT_W]   = m_snap[k][CNT_W-1:0];
        end
        sb_q.push_back(e);
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("sb_tick", 64'(tick), 64'(mon_e.tick));
            check("sb_wrap", 64'(wrap), 64'(mon_e.wrap));
            check("sb_running", 64'(running), 64'(mon_e.running));
            check("sb_cnt", 64'(cnt), 64'(mon_e.cnt));
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
            check("sb_snap", 64'(snap_out), 64'(mon_e.snap));
`endif
        end
    end

    task automatic step();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_div(input int ch, input int v);
        div[ch*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic set_mod(input int ch, input int v);
        mod[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    function automatic logic [CNT_W-1:0] get_cnt(input int ch);
        return cnt[ch*CNT_W +: CNT_W];
    endfunction

    int   ticks0;
    bit   wrap0_prev;
    int   cnt1_prev;
    bit   got_wrap1;
    bit   found;
    bit   snapped;
    int   snap_i;

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            m_run[k] = 0; m_pre[k] = 0; m_cnt[k] = 0; m_tick[k] = 0; m_wrap[k] = 0; m_snap[k] = 0;
        end
        rst = 1'b1; run = '0; clr = '0; div = '0; mod = '0;
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
        snap = 1'b0;
`endif
        step();
        step();
        check("reset_tick", 64'(tick), 64'(0));
        check("reset_cnt", 64'(cnt), 64'(0));
        check("reset_running", 64'(running), 64'(0));
        rst = 1'b0;

        // ch2: period 5, count 0..3; ch3: tick every cycle, full 8-bit wrap.
        set_div(2, 4); set_mod(2, 3);
        set_div(3, 0); set_mod(3, 255);
        run = 4'b1100;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i < 25) begin
                check("div4_tick", 64'(tick[2]), 64'((i > 0) && (i % 5 == 0)));
                check("div4_cnt", 64'(get_cnt(2)), 64'((i < 6) ? 0 : ((i - 1) / 5) % 4));
                check("div4_wrap", 64'(wrap[2]), 64'(i == 21));
            end
            if (i >= 1) begin
                check("div0_tick", 64'(tick[3]), 64'(1));
                check("div0_cnt", 64'(get_cnt(3)), 64'((i - 1) % 256));
                check("div0_wrap", 64'(wrap[3]), 64'(i == 257));
            end
        end
        run = '0; clr = '1;
        step();
        clr = '0;

        // ch1 cascaded on ch0 wrap; its own iDIV is set but must be ignored.
        set_div(0, 1); set_mod(0, 9);
        set_div(1, 3); set_mod(1, 5);
        run = 4'b0011;
        ticks0 = 0; wrap0_prev = 1'b0; cnt1_prev = 0; got_wrap1 = 1'b0; snapped = 1'b0; snap_i = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            check("casc_tick1", 64'(tick[1]), 64'(0));
            if (wrap0_prev) check("casc_follow", 64'(get_cnt(1)), 64'((cnt1_prev + 1) % 6));
            if (wrap[1] && !got_wrap1) begin
                got_wrap1 = 1'b1;
                check("casc_wrap_ticks", 64'(ticks0), 64'(60));
            end
            ticks0     = ticks0 + int'(tick[0]);
            wrap0_prev = wrap[0];
            cnt1_prev  = int'(get_cnt(1));
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
            snap = 1'b0;
            if (!snapped && get_cnt(0) == 7 && get_cnt(1) == 2) begin
                snap = 1'b1; snapped = 1'b1; snap_i = i;
            end else if (snapped && i > snap_i && i <= snap_i + 12) begin
                check("snap_hold", 64'(snap_out[15:0]), 64'(16'h0207));
            end
`endif
        end
        check("casc_wrap_seen", 64'(got_wrap1), 64'(1));
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
        check("snap_seen", 64'(snapped), 64'(1));
        snap = 1'b0;
`endif
        run = '0; clr = '1;
        step();
        clr = '0;

        // Stop at cnt=2 for 7 cycles, then resume: phase and count must carry on.
        set_div(2, 4); set_mod(2, 9);
        run = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (get_cnt(2) == 2 && !tick[2]) found = 1'b1;
        end
        check("stop_reach_cnt2", 64'(found), 64'(1));
        run[2] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("stop_hold_cnt", 64'(get_cnt(2)), 64'(2));
            check("stop_running", 64'(running[2]), 64'(0));
            check("stop_tick", 64'(tick[2]), 64'(0));
        end
        run[2] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            check("resume_tick", 64'(tick[2]), 64'(j == 4));
            check("resume_cnt", 64'(get_cnt(2)), 64'((j < 5) ? 2 : 3));
        end

        // Clear on a cycle with an advance pending.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick[2]) found = 1'b1;
        end
        check("clr_reach_tick", 64'(found), 64'(1));
        clr[2] = 1'b1;
        step();
        check("clr_cnt", 64'(get_cnt(2)), 64'(0));
        check("clr_wrap", 64'(wrap[2]), 64'(0));
        check("clr_running", 64'(running[2]), 64'(0));
        clr[2] = 1'b0;

        // Reset mid-count, then time the first tick after release.
        run = 4'b1100;
        for (int i = 0; i < 30; i++) step();
        rst = 1'b1;
        step();
        check("rst_tick", 64'(tick), 64'(0));
        check("rst_wrap", 64'(wrap), 64'(0));
        check("rst_running", 64'(running), 64'(0));
        check("rst_cnt", 64'(cnt), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check("rst_first_tick", 64'(tick[2]), 64'(k == 5));
        end

        // Randomised traffic against the model.
        for (int k = 0; k < N_CH; k++) begin
            set_div(k, int'($urandom_range(0, 3)));
            set_mod(k, int'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) run = 4'($urandom) | 4'($urandom);
            clr = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            if ($urandom_range(0, 29) == 0) set_div(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            if ($urandom_range(0, 29) == 0) set_mod(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 199) == 0);
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
            snap = ($urandom_range(0, 9) == 0);
`endif
            step();
        end
        rst = 1'b0; clr = '0;
`ifdef DIV_COUNTER_BANK_SNAPSHOT_EN
        snap = 1'b0;
`endif
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
